// File: rtl/mem_wb_skid_stage.sv
// Elastic MEM->WB pipeline stage: 2-entry main/skid register with valid/ready on both sides.
// Define MEM_WB_PERF_EN to add saturating stall_cycles/bubble_cycles counters.
module mem_wb_skid_stage #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned RESULT_SRC_WIDTH = 2,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_pc_plus4,
  input  logic [DATA_WIDTH-1:0]       in_alu_result,
  input  logic [DATA_WIDTH-1:0]       in_read_data,
  input  logic                        in_reg_write,
  input  logic [RESULT_SRC_WIDTH-1:0] in_result_src,
  input  logic [REG_ADDR_WIDTH-1:0]   in_rd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_pc_plus4,
  output logic [DATA_WIDTH-1:0]       out_alu_result,
  output logic [DATA_WIDTH-1:0]       out_read_data,
  output logic                        out_reg_write,
  output logic [RESULT_SRC_WIDTH-1:0] out_result_src,
  output logic [REG_ADDR_WIDTH-1:0]   out_rd,
  output logic [1:0]                  occupancy
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]        stall_cycles,
  output logic [CNT_WIDTH-1:0]        bubble_cycles
`endif
);

  localparam int unsigned PW = 3 * DATA_WIDTH + 1 + RESULT_SRC_WIDTH + REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skid_q;
  logic [PW-1:0]   in_pl;
  logic            main_reg_write;
  logic            accept;
  logic            drain;

  assign in_pl = {in_pc_plus4, in_alu_result, in_read_data, in_reg_write, in_result_src, in_rd};

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign {out_pc_plus4, out_alu_result, out_read_data, main_reg_write, out_result_src, out_rd} = main_q;
  // A stale main entry must never trigger a register-file write.
  assign out_reg_write = main_reg_write & out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_pl;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= in_pl;
          end else if (accept) begin
            skid_q <= in_pl;
            state  <= FULL;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef MEM_WB_PERF_EN
  // Counters follow the registered out_valid, so flush cycles count by pre-flush state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (!out_valid && (bubble_cycles != '1))
        bubble_cycles <= bubble_cycles + 1'b1;
    end
  end
`endif

endmodule
